// File: rtl/systolic_host_sequencer.sv
// Host-side sequencer: loads A/B rows, starts the array, streams results back.
// Optional watchdog in WAIT enabled by macro SYSTOLIC_SEQ_TIMEOUT_EN.
module systolic_host_sequencer #(
  parameter int ARRAY_SIZE     = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int ACC_WIDTH      = 32,
  parameter int ADDR_WIDTH     = $clog2(ARRAY_SIZE),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_gelu,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_data,
  output logic                             out_last,
  output logic                             seq_busy,
  output logic                             seq_done,
  output logic                             acc_wr_en_a,
  output logic                             acc_wr_en_b,
  output logic [ADDR_WIDTH-1:0]            acc_wr_row_addr,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] acc_wr_data,
  output logic                             acc_start,
  input  logic                             acc_busy,
  input  logic                             acc_done,
  output logic [ADDR_WIDTH-1:0]            acc_rd_row_addr,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  acc_rd_data,
  output logic                             acc_gelu_en
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
  ,
  output logic                             timeout_err
`endif
);

  localparam int RW = ADDR_WIDTH + 1;
  localparam logic [RW-1:0] LAST  = RW'(ARRAY_SIZE - 1);
  localparam logic [RW-1:0] NROWS = RW'(ARRAY_SIZE);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, SETTLE, START, WAIT, READ, FIN
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_cnt;
  logic            gelu_q;
  logic            load_en;

`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  assign seq_busy    = (state_q != IDLE);
  assign acc_gelu_en = (state_q == READ) && gelu_q;
  assign load_en     = (state_q == READ) && (row_cnt != NROWS)
                     && (!out_valid || out_ready);

  // Next-state and handshake decode; cmd_ready held low while in reset.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    acc_start = 1'b0;
    seq_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = rst_n && !acc_busy;
        if (cmd_valid && cmd_ready) state_d = LOAD_A;
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid && row_cnt == LAST) state_d = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid && row_cnt == LAST) state_d = SETTLE;
      end
      SETTLE: state_d = START;
      START: begin
        acc_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (acc_done) state_d = READ;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
        else if (to_hit) state_d = FIN;
`endif
      end
      READ: begin
        if (out_valid && out_ready && out_last) state_d = FIN;
      end
      FIN: begin
        seq_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, row counter, write port and one-entry output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      row_cnt         <= '0;
      gelu_q          <= 1'b0;
      acc_wr_en_a     <= 1'b0;
      acc_wr_en_b     <= 1'b0;
      acc_wr_row_addr <= '0;
      acc_wr_data     <= '0;
      acc_rd_row_addr <= '0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_wr_en_a <= 1'b0;
      acc_wr_en_b <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            gelu_q  <= cmd_gelu;
            row_cnt <= '0;
          end
        end
        LOAD_A, LOAD_B: begin
          if (in_valid) begin
            acc_wr_en_a     <= (state_q == LOAD_A);
            acc_wr_en_b     <= (state_q == LOAD_B);
            acc_wr_row_addr <= row_cnt[ADDR_WIDTH-1:0];
            acc_wr_data     <= in_data;
            row_cnt <= (row_cnt == LAST) ? '0 : row_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (acc_done) begin
            row_cnt         <= '0;
            acc_rd_row_addr <= '0;
          end
        end
        READ: begin
          if (load_en) begin
            out_data  <= acc_rd_data;
            out_valid <= 1'b1;
            out_last  <= (row_cnt == LAST);
            row_cnt   <= row_cnt + 1'b1;
            if (row_cnt != LAST)
              acc_rd_row_addr <= row_cnt[ADDR_WIDTH-1:0] + 1'b1;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
  // Watchdog: counts WAIT cycles, flags a sticky error on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == WAIT && !acc_done) to_cnt <= to_cnt + 1'b1;
      else to_cnt <= '0;
      if (state_q == IDLE && cmd_valid && cmd_ready)
        timeout_err <= 1'b0;
      else if (state_q == WAIT && !acc_done && to_hit)
        timeout_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/systolic_host_sequencer.md
Name: systolic_host_sequencer

Overview:
Host-side initiator for the matrix-multiply accelerator's load/control/read interface.
- Accepts a job command, then streams ARRAY_SIZE rows of A and ARRAY_SIZE rows of B over a valid/ready input stream and writes them into the accelerator.
- Pulses start, waits for done, then reads result rows back and emits them on a valid/ready output stream.
- Sits between the DMA/host fabric and the accelerator top level.

Parameters:
- ARRAY_SIZE, 32, matrix dimension N (rows per matrix, elements per row).
- DATA_WIDTH, 16, input element width (BF16).
- ACC_WIDTH, 32, result element width (FP32).
- ADDR_WIDTH, $clog2(ARRAY_SIZE), row address width.
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT (only used with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- cmd_valid  in  1  job request
- cmd_ready  out  1  job accepted when both high
- cmd_gelu  in  1  apply GeLU on readback for this job
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when both high
- in_data  in  ARRAY_SIZE x DATA_WIDTH  input row (signed elements)
- out_valid  out  1  result row valid
- out_ready  in  1  result row consumed when both high
- out_data  out  ARRAY_SIZE x ACC_WIDTH  result row (signed)
- out_last  out  1  marks row ARRAY_SIZE-1
- seq_busy  out  1  high whenever state != IDLE
- seq_done  out  1  one-cycle pulse at job completion
- acc_wr_en_a  out  1  accelerator A row write
- acc_wr_en_b  out  1  accelerator B row write
- acc_wr_row_addr  out  ADDR_WIDTH  write row address
- acc_wr_data  out  ARRAY_SIZE x DATA_WIDTH  write row data
- acc_start  out  1  accelerator start pulse
- acc_busy  in  1  accelerator busy
- acc_done  in  1  accelerator results valid
- acc_rd_row_addr  out  ADDR_WIDTH  result row select
- acc_rd_data  in  ARRAY_SIZE x ACC_WIDTH  result row; combinational from acc_rd_row_addr
- acc_gelu_en  out  1  GeLU select to accelerator

Behaviour:
Reset:
- All outputs 0, state IDLE, row counter 0, out_data all zero.
- Reset mid-job abandons the job; no partial outputs after deassertion.

States: IDLE, LOAD_A, LOAD_B, SETTLE, START, WAIT, READ, FIN.
- IDLE:
  - cmd_ready = !acc_busy.
  - On cmd_valid && cmd_ready: latch cmd_gelu into gelu_q, row_cnt <= 0, go LOAD_A.
- LOAD_A:
  - in_ready = 1.
  - Each accepted beat registers acc_wr_en_a=1, acc_wr_row_addr=row_cnt, acc_wr_data=in_data for exactly the next cycle; row_cnt++.
  - After beat ARRAY_SIZE-1: row_cnt wraps to 0, go LOAD_B.
  - No beat accepted means acc_wr_en_a=0 the next cycle (gaps allowed).
- LOAD_B: identical to LOAD_A using acc_wr_en_b. After the last beat, go SETTLE.
- SETTLE:
  - in_ready = 0.
  - Lasts one cycle, during which the final B write is presented.
  - Guarantees start is never coincident with a write.
- START: acc_start = 1 for exactly one cycle, then go WAIT.
- WAIT: on acc_done = 1, go READ with row_cnt = 0.
- READ:
  - acc_rd_row_addr = row_cnt (registered).
  - acc_gelu_en = gelu_q; held during READ, 0 elsewhere.
  - One-entry output register is loadable when !out_valid || out_ready.
  - On load: out_data <= acc_rd_data, out_valid <= 1, out_last <= (row_cnt == ARRAY_SIZE-1), row_cnt++.
  - After the last row is loaded, no further loads. When the last row is consumed: out_valid <= 0, go FIN.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - Full-throughput case: out_ready held high gives one row per cycle after a one-cycle fill latency.
- FIN: seq_done = 1 for one cycle, go IDLE.

General rules:
- cmd_valid outside IDLE is ignored (cmd_ready = 0).
- in_valid outside LOAD_A/LOAD_B is ignored.
- acc_done seen in any state other than WAIT is ignored.
- Counter widths: row_cnt is ADDR_WIDTH+1 bits; no truncation at ARRAY_SIZE.

Optional Feature:
Macro SYSTOLIC_SEQ_TIMEOUT_EN.
- Defined:
  - Adds output timeout_err (1 bit, sticky, reset 0, cleared on next cmd accept).
  - A WAIT-state counter counts cycles. If it reaches TIMEOUT_CYCLES without acc_done, set timeout_err, pulse seq_done, go IDLE, emit no output rows.
- Undefined: no port, no counter; WAIT waits indefinitely.

Test Plan:
- Identity check: N=4 build, A=identity, B rows {1,2,3,4}..{13,14,15,16}, cmd_gelu=0, accelerator model → 4 output rows equal to B (widened to FP32); out_last only on row 3; seq_done one cycle after final handshake.
- Input gaps: in_valid toggled 1/0 every cycle during load → acc_wr_en_a/b high only the cycle after each accepted beat, with addresses 0..3 in order; acc_start exactly once, at least 1 cycle after the last write.
- Output backpressure: out_ready low 5 cycles with row 0 pending → out_valid stays high, out_data unchanged, acc_rd_row_addr does not pass 1; then out_ready held high → rows 1..3 on consecutive cycles.
- Command blocking: cmd_valid with acc_busy=1 → cmd_ready=0. Second cmd_valid during LOAD_B → not accepted; state unaffected.
- Reset mid-job: rst_n asserted during READ after 2 rows → all outputs 0 immediately. A new job after release completes normally with 4 rows.
- Timeout (SYSTOLIC_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): acc_done never asserted → timeout_err=1 and seq_done pulse 16 cycles after WAIT entry; no out_valid; next cmd accept clears timeout_err.
